// File: rtl/iomem_master.sv
// Single-outstanding requester-to-iomem bridge: accepts one request, runs one bus cycle, returns one response.
// Optional bus timeout when IOMEM_TIMEOUT_EN is defined; otherwise BUSY waits for the responder indefinitely.
module iomem_master #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    input  logic [3:0]  req_wstrb_i,
    output logic        resp_valid_o,
    input  logic        resp_ready_i,
    output logic [31:0] resp_rdata_o,
    output logic        resp_err_o,
    output logic        iomem_valid_o,
    input  logic        iomem_ready_i,
    output logic [31:0] iomem_addr_o,
    output logic [31:0] iomem_wdata_o,
    output logic [3:0]  iomem_wstrb_o,
    input  logic [31:0] iomem_rdata_i,
    output logic        busy_o
);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t      state, state_nxt;
    logic        accept, misaligned, handshake, timeout;
    logic        valid_q, resp_valid_q, resp_err_q;
    logic [31:0] addr_q, wdata_q, rdata_q;
    logic [3:0]  wstrb_q;

    assign req_ready_o = (state == IDLE);
    assign busy_o      = (state != IDLE);
    assign accept      = req_valid_i & req_ready_o;
    assign misaligned  = |req_addr_i[1:0];
    // valid_q mirrors BUSY exactly, so ready outside a bus cycle is ignored
    assign handshake   = valid_q & iomem_ready_i;

`ifdef IOMEM_TIMEOUT_EN
    logic [15:0] tmo_cnt;

    assign timeout = valid_q & ~iomem_ready_i & (tmo_cnt == 16'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tmo_cnt <= '0;
        end else if (state != BUSY) begin
            tmo_cnt <= '0;
        end else if (!iomem_ready_i) begin
            tmo_cnt <= tmo_cnt + 16'd1;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = misaligned ? RESP : BUSY;
            BUSY: if (handshake || timeout) state_nxt = RESP;
            RESP: if (resp_ready_i) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q      <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            rdata_q      <= '0;
        end else begin
            valid_q      <= (state_nxt == BUSY);
            resp_valid_q <= (state_nxt == RESP);
            if (accept && !misaligned) begin
                addr_q  <= req_addr_i;
                wdata_q <= req_wdata_i;
                wstrb_q <= req_wstrb_i;
            end
            if (accept && misaligned) begin
                rdata_q    <= '0;
                resp_err_q <= 1'b1;
            end else if (handshake) begin
                rdata_q    <= (wstrb_q == 4'b0000) ? iomem_rdata_i : 32'd0;
                resp_err_q <= 1'b0;
            end else if (timeout) begin
                rdata_q    <= '0;
                resp_err_q <= 1'b1;
            end
        end
    end

    assign iomem_valid_o = valid_q;
    assign iomem_addr_o  = addr_q;
    assign iomem_wdata_o = wdata_q;
    assign iomem_wstrb_o = wstrb_q;
    assign resp_valid_o  = resp_valid_q;
    assign resp_rdata_o  = rdata_q;
    assign resp_err_o    = resp_err_q;

endmodule

// File: tb/tb_iomem_master.sv
// Bench for iomem_master: directed scenarios plus random transactions against a transaction-level model.
module tb_iomem_master;

    localparam int TO = 8;
`ifdef IOMEM_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_wstrb;
    logic        resp_valid, resp_ready, resp_err;
    logic [31:0] resp_rdata;
    logic        iomem_valid, iomem_ready;
    logic [31:0] iomem_addr, iomem_wdata, iomem_rdata;
    logic [3:0]  iomem_wstrb;
    logic        busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    iomem_master #(.TIMEOUT_CYCLES(TO)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_wstrb_i(req_wstrb),
        .resp_valid_o(resp_valid), .resp_ready_i(resp_ready),
        .resp_rdata_o(resp_rdata), .resp_err_o(resp_err),
        .iomem_valid_o(iomem_valid), .iomem_ready_i(iomem_ready),
        .iomem_addr_o(iomem_addr), .iomem_wdata_o(iomem_wdata),
        .iomem_wstrb_o(iomem_wstrb), .iomem_rdata_i(iomem_rdata),
        .busy_o(busy)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Responder noise while no bus cycle is active; the DUT must ignore it.
    task automatic junk_bus();
        iomem_ready = 1'($urandom);
        iomem_rdata = $urandom;
    endtask

    // One full transaction. d = cycles after first valid until responder ready, r = resp stall cycles.
    task automatic run_txn(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                           input int d, input int r, input logic [31:0] rd);
        bit          mis, to;
        int          n, nv;
        logic [31:0] er;
        logic        ee;
        mis = (a[1:0] != 2'b00);
        to  = !mis && TMO_EN && (d >= TO);
        ee  = mis || to;
        er  = (mis || to || ws != 4'b0000) ? 32'd0 : rd;

        req_valid = 1'b1; req_addr = a; req_wdata = wd; req_wstrb = ws;
        n = 0;
        while (!req_ready && n < 50) begin
            junk_bus();
            step();
            n++;
        end
        check_val("accept_wait", 32'(n < 50), 32'd1);
        junk_bus();
        step();
        req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom; req_wstrb = 4'($urandom);

        if (!mis) begin
            nv = to ? TO : d + 1;
            for (int k = 0; k < nv; k++) begin
                check_val("bus_valid", 32'(iomem_valid), 32'd1);
                check_val("bus_addr", iomem_addr, a);
                check_val("bus_wdata", iomem_wdata, wd);
                check_val("bus_wstrb", 32'(iomem_wstrb), 32'(ws));
                check_val("resp_early", 32'(resp_valid), 32'd0);
                iomem_ready = (k == d);
                iomem_rdata = (k == d) ? rd : $urandom;
                step();
            end
        end
        iomem_ready = 1'b0;
        check_val("bus_drop", 32'(iomem_valid), 32'd0);
        check_val("resp_lat", 32'(resp_valid), 32'd1);

        for (int k = 0; k < r; k++) begin
            req_valid = 1'b1; req_addr = $urandom; req_wstrb = 4'($urandom);
            resp_ready = 1'b0;
            junk_bus();
            check_val("resp_hold", 32'(resp_valid), 32'd1);
            check_val("resp_rdata_hold", resp_rdata, er);
            check_val("resp_err_hold", 32'(resp_err), 32'(ee));
            check_val("stall_ready", 32'(req_ready), 32'd0);
            check_val("stall_busy", 32'(busy), 32'd1);
            check_val("stall_bus", 32'(iomem_valid), 32'd0);
            step();
        end
        req_valid = 1'b0;
        resp_ready = 1'b1;
        iomem_ready = 1'b0;
        check_val("resp_valid", 32'(resp_valid), 32'd1);
        check_val("resp_rdata", resp_rdata, er);
        check_val("resp_err", 32'(resp_err), 32'(ee));
        step();
        resp_ready = 1'b0;
        check_val("resp_done", 32'(resp_valid), 32'd0);
        check_val("idle_ready", 32'(req_ready), 32'd1);
    endtask

    initial begin
        logic [31:0] a;
        rst_n = 1'b0;
        req_valid = 1'b0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
        resp_ready = 1'b0; iomem_ready = 1'b0; iomem_rdata = '0;
        step();
        check_val("rst_bus_valid", 32'(iomem_valid), 32'd0);
        check_val("rst_bus_addr", iomem_addr, 32'd0);
        check_val("rst_bus_wdata", iomem_wdata, 32'd0);
        check_val("rst_bus_wstrb", 32'(iomem_wstrb), 32'd0);
        check_val("rst_resp_valid", 32'(resp_valid), 32'd0);
        check_val("rst_resp_err", 32'(resp_err), 32'd0);
        check_val("rst_resp_rdata", resp_rdata, 32'd0);
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_ready", 32'(req_ready), 32'd1);
        step();
        rst_n = 1'b1;
        step();

        run_txn(32'h4000_0010, 32'h0, 4'b0000, 16, 0, 32'h1234_5678);
        run_txn(32'h3000_0000, 32'h0, 4'b0000, 0, 0, 32'h0000_00A5);
        run_txn(32'h4000_0004, 32'hCAFE_F00D, 4'b0011, 2, 5, 32'hDEAD_BEEF);
        run_txn(32'h4000_0002, 32'h0, 4'b0000, 0, 1, 32'h0);
        run_txn(32'h5000_0000, 32'h0, 4'b0000, TMO_EN ? 1000 : 120, 1, 32'h7777_0001);
        run_txn(32'h5000_0008, 32'h0, 4'b0000, TO - 1, 0, 32'h0BAD_CAFE);

        // Reset dropped mid bus cycle, then a stray ready after release.
        req_valid = 1'b1; req_addr = 32'h6000_0000; req_wstrb = 4'b0000;
        step();
        req_valid = 1'b0;
        check_val("mid_rst_busy", 32'(iomem_valid), 32'd1);
        step(); step(); step();
        #2 rst_n = 1'b0;
        #1;
        check_val("async_rst_valid", 32'(iomem_valid), 32'd0);
        check_val("async_rst_busy", 32'(busy), 32'd0);
        step(); step(); step();
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            iomem_ready = 1'b1;
            iomem_rdata = $urandom;
            step();
            check_val("post_rst_resp", 32'(resp_valid), 32'd0);
            check_val("post_rst_bus", 32'(iomem_valid), 32'd0);
            check_val("post_rst_ready", 32'(req_ready), 32'd1);
        end
        iomem_ready = 1'b0;

        for (int t = 0; t < 150; t++) begin
            a = $urandom;
            a[1:0] = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            run_txn(a, $urandom, ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom),
                    int'($urandom_range(0, 12)), int'($urandom_range(0, 4)), $urandom);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
